// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register plus the EX-side operand logic of the RV32I core.
// It captures the decoded operands and controls and registers the 4-bit ALU
// code. It forwards rs1/rs2 from EX/MEM and MEM/WB, and it detects load-use
// hazards so that it can insert a bubble.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_*                       decoded instruction from the ID stage
//   hold                       freeze the stage (downstream stall)
//   flush                      kill the incoming instruction (taken branch)
//   exmem_*, memwb_*           writeback candidates for forwarding
//   load_use_stall             hold PC and IF/ID for one bubble
//   A, B, ALUOp                ALU operands and operation code
//   ex_store_data              forwarded rs2 value for stores
//   ex_rd, ex_valid, ex_*      registered destination and controls
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            hold,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            load_use_stall,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALUOp,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic [3:0]      alu_ctl;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } ex_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  ex_t ex_d, ex_q;

  // Main control plus funct fields -> ALU code. funct7[5] only selects SUB
  // for R-type; for I-type it is part of the immediate and must be ignored.
  function automatic logic [3:0] alu_decode(input logic [1:0] op,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    logic [3:0] code;
    code = ALU_ADD;
    case (op)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      default: begin
        case (f3)
          3'b000:  code = (op == 2'b10 && f7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  code = ALU_AND;
          3'b110:  code = ALU_OR;
          default: code = ALU_ADD;
        endcase
      end
    endcase
    return code;
  endfunction

  // EX/MEM is the younger producer, so it is tested first. Index 0 is
  // hard-wired zero and never forwards.
  function automatic logic [XLEN-1:0] forward(input logic [REGW-1:0] rs,
                                              input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] val;
    val = stored;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs)
      val = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs)
      val = memwb_result;
    return val;
  endfunction

  // The load in EX delivers its data one stage too late for a dependent
  // instruction in ID. This is purely combinational on the current EX
  // contents, so it stays asserted across hold and drops once the bubble is in.
  assign load_use_stall = ex_q.valid && ex_q.mem_read && ex_q.rd != '0 &&
                          id_valid && (ex_q.rd == id_rs1 || ex_q.rd == id_rs2);

  // NOTE: every always_comb output gets a default first (here: keep current
  // contents) so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    ex_d = ex_q;
    if (flush || (!hold && load_use_stall)) begin
      // Bubble: controls and destination cleared; operand fields don't care.
      ex_d.valid      = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.mem_to_reg = 1'b0;
      ex_d.rd         = '0;
      ex_d.alu_ctl    = ALU_AND;
    end else if (!hold) begin
      ex_d.valid      = id_valid;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.alu_src    = id_alu_src;
      ex_d.alu_ctl    = alu_decode(id_alu_op, id_funct3, id_funct7b5);
      ex_d.rd         = id_rd;
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
      ex_d.rs1_data   = id_rs1_data;
      ex_d.rs2_data   = id_rs2_data;
      ex_d.imm        = id_imm;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  always_comb begin
    A             = forward(ex_q.rs1, ex_q.rs1_data);
    ex_store_data = forward(ex_q.rs2, ex_q.rs2_data);
    B             = ex_q.alu_src ? ex_q.imm : ex_store_data;
  end

  assign ALUOp         = ex_q.alu_ctl;
  assign ex_rd         = ex_q.rd;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. The stimulus process drives one cycle at a
// time and pushes hand-computed expectations, tagged with the cycle in which
// they must hold, into a scoreboard queue. A monitor on the falling edge pops
// every expectation due in that cycle and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic [1:0]      id_alu_op;
  logic            id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic            hold, flush;
  logic            exmem_reg_write, memwb_reg_write;
  logic [REGW-1:0] exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            load_use_stall;
  logic [XLEN-1:0] A, B, ex_store_data;
  logic [3:0]      ALUOp;
  logic [REGW-1:0] ex_rd;
  logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .hold(hold), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .A(A), .B(B), .ALUOp(ALUOp),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  typedef enum int {S_A, S_B, S_OP, S_SD, S_VALID, S_RD, S_RW, S_MR, S_STALL} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
    int          tgt;
  } exp_t;

  exp_t sb[$];
  int   applied     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc++;

  // dly = 0: must hold in the current cycle; dly = 1: after the next edge.
  task automatic expect_sig(input string name, input sig_e sig,
                            input logic [31:0] exp, input int dly);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    e.tgt  = cyc + dly;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_A:     return A;
      S_B:     return B;
      S_OP:    return {28'd0, ALUOp};
      S_SD:    return ex_store_data;
      S_VALID: return {31'd0, ex_valid};
      S_RD:    return {27'd0, ex_rd};
      S_RW:    return {31'd0, ex_reg_write};
      S_MR:    return {31'd0, ex_mem_read};
      default: return {31'd0, load_use_stall};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        keep[$];
    logic [31:0] act;
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].tgt == cyc) begin
        act = actual(sb[i].sig);
        applied++;
        if (act !== sb[i].exp) begin
          miscompares++;
          $display("FAIL %s (cycle %0d): got %0h, expected %0h",
                   sb[i].name, cyc, act, sb[i].exp);
        end
      end else if (sb[i].tgt < cyc) begin
        applied++;
        miscompares++;
        $display("FAIL %s: expectation never sampled, expected %0h", sb[i].name, sb[i].exp);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; id_valid = 1'b0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_funct3 = '0; id_funct7b5 = 1'b0; id_alu_op = '0; id_alu_src = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    hold = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  // Decode vectors: alu_op, funct3, funct7b5 -> expected ALUOp.
  logic [1:0] dv_op [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
  logic [2:0] dv_f3 [6] = '{3'b110, 3'b000, 3'b000, 3'b111, 3'b100, 3'b000};
  logic       dv_f7 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] dv_exp[6] = '{4'b0001, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 4'b0010};

  initial begin
    idle();
    // Reset with a live instruction on the inputs.
    reset = 1'b1; id_valid = 1'b1; id_reg_write = 1'b1; id_rs1_data = 32'd77;
    step(); step();
    expect_sig("rst_aluop", S_OP, 0, 0);
    expect_sig("rst_valid", S_VALID, 0, 0);
    expect_sig("rst_regwr", S_RW, 0, 0);
    expect_sig("rst_a", S_A, 0, 0);
    expect_sig("rst_b", S_B, 0, 0);

    // R-type SUB, one-edge latency.
    idle();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd4;
    id_rs1_data = 32'd30; id_rs2_data = 32'd10;
    id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7b5 = 1'b1; id_reg_write = 1'b1;
    expect_sig("sub_stall", S_STALL, 0, 0);
    expect_sig("sub_a", S_A, 30, 1);
    expect_sig("sub_b", S_B, 10, 1);
    expect_sig("sub_op", S_OP, 4'b0110, 1);
    expect_sig("sub_valid", S_VALID, 1, 1);
    expect_sig("sub_rd", S_RD, 4, 1);
    step();

    // I-type ANDI with immediate on B.
    id_alu_op = 2'b11; id_funct3 = 3'b111; id_imm = 32'd7; id_alu_src = 1'b1;
    expect_sig("andi_op", S_OP, 4'b0000, 1);
    expect_sig("andi_b", S_B, 7, 1);
    expect_sig("andi_sd", S_SD, 10, 1);
    step();

    id_alu_src = 1'b0;
    for (int i = 0; i < 6; i++) begin
      id_alu_op = dv_op[i]; id_funct3 = dv_f3[i]; id_funct7b5 = dv_f7[i];
      expect_sig($sformatf("decode_%0d", i), S_OP, {28'd0, dv_exp[i]}, 1);
      step();
    end

    // Forwarding priority on rs1, then rs2 from MEM/WB.
    idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_data = 32'd11;
    id_rs2 = 5'd6; id_rs2_data = 32'd22; id_rd = 5'd8;
    step();
    hold = 1'b1; id_rs1_data = 32'd1234;
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'd40;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'd99;
    expect_sig("fwd_exmem_wins", S_A, 40, 0);
    expect_sig("fwd_b_none", S_B, 22, 0);
    step();
    exmem_reg_write = 1'b0;
    expect_sig("fwd_memwb", S_A, 99, 0);
    step();
    memwb_rd = 5'd6; memwb_result = 32'd77;
    expect_sig("fwd_a_none", S_A, 11, 0);
    expect_sig("fwd_b_memwb", S_B, 77, 0);
    expect_sig("fwd_sd_memwb", S_SD, 77, 0);
    step();

    // Index 0 never forwards.
    idle();
    id_valid = 1'b1; id_rs1_data = 32'd55; id_rs2_data = 32'd66;
    step();
    hold = 1'b1;
    exmem_reg_write = 1'b1; exmem_result = 32'd40;
    memwb_reg_write = 1'b1; memwb_result = 32'd99;
    expect_sig("x0_a", S_A, 55, 0);
    expect_sig("x0_b", S_B, 66, 0);
    step();

    // Load-use: load to x3 followed by a consumer of x3 on rs2.
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
    id_rd = 5'd3; id_rs1 = 5'd1; id_rs2 = 5'd2;
    step();
    id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_rd = 5'd10; id_rs1 = 5'd7; id_rs2 = 5'd3;
    id_alu_op = 2'b10; id_funct7b5 = 1'b1;
    expect_sig("lu_stall", S_STALL, 1, 0);
    expect_sig("lu_bubble_valid", S_VALID, 0, 1);
    expect_sig("lu_bubble_op", S_OP, 0, 1);
    expect_sig("lu_bubble_mr", S_MR, 0, 1);
    step();
    expect_sig("lu_stall_drop", S_STALL, 0, 0);
    expect_sig("lu_consumer_valid", S_VALID, 1, 1);
    expect_sig("lu_consumer_op", S_OP, 4'b0110, 1);
    step();

    // Load-use under hold: hold wins, bubble enters on the first free edge.
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd3;
    step();
    id_mem_read = 1'b0; id_rd = 5'd11; id_rs1 = 5'd3;
    hold = 1'b1;
    expect_sig("lu_hold_stall", S_STALL, 1, 0);
    expect_sig("lu_hold_valid", S_VALID, 1, 1);
    expect_sig("lu_hold_mr", S_MR, 1, 1);
    step();
    hold = 1'b0;
    expect_sig("lu_release_stall", S_STALL, 1, 0);
    expect_sig("lu_release_valid", S_VALID, 0, 1);
    step();
    expect_sig("lu_release_drop", S_STALL, 0, 0);
    step();

    // Load to x0, and a matching index without id_valid: no stall.
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd0;
    step();
    id_mem_read = 1'b0;
    expect_sig("lu_x0", S_STALL, 0, 0);
    step();
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd9;
    step();
    id_valid = 1'b0; id_mem_read = 1'b0; id_rs1 = 5'd9;
    expect_sig("lu_no_valid", S_STALL, 0, 0);
    step();

    // Hold for three edges with changing inputs, then flush under hold.
    idle();
    id_valid = 1'b1; id_rs1 = 5'd12; id_rs1_data = 32'd123; id_alu_op = 2'b01; id_rd = 5'd9;
    step();
    for (int i = 0; i < 3; i++) begin
      hold = 1'b1;
      id_rs1_data = 32'(i * 17 + 1); id_alu_op = 2'b10; id_funct3 = 3'b111;
      id_rd = 5'(i + 20);
      expect_sig($sformatf("hold_a_%0d", i), S_A, 123, 1);
      expect_sig($sformatf("hold_op_%0d", i), S_OP, 4'b0110, 1);
      expect_sig($sformatf("hold_rd_%0d", i), S_RD, 9, 1);
      step();
    end
    flush = 1'b1;
    expect_sig("flush_valid", S_VALID, 0, 1);
    expect_sig("flush_op", S_OP, 0, 1);
    expect_sig("flush_rd", S_RD, 0, 1);
    step();

    // Reset mid-stream discards the held instruction.
    idle();
    id_valid = 1'b1; id_rd = 5'd5; id_reg_write = 1'b1;
    step();
    reset = 1'b1;
    expect_sig("midrst_valid", S_VALID, 0, 1);
    expect_sig("midrst_op", S_OP, 0, 1);
    expect_sig("midrst_rd", S_RD, 0, 1);
    step();
    idle();
    step(); step(); step();

    foreach (sb[i]) begin
      applied++;
      miscompares++;
      $display("FAIL %s: expectation never sampled, expected %0h", sb[i].name, sb[i].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand logic for the pipelined RV32I core; sits directly upstream of the ALU and drives its A, B and 4-bit ALUOp.
- Captures decoded operands and controls, and decodes the 2-bit main alu_op, funct3 and funct7[5] into the ALU's 4-bit code.
- Forwards from EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
id_valid  in  1  decode slot holds a real instruction
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REGW  register indices
id_funct3  in  3  instr[14:12]
id_funct7b5  in  1  instr[30]
id_alu_op  in  2  main control: 00 add, 01 sub, 10 R-type, 11 I-type ALU
id_alu_src  in  1  1 = B takes immediate
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  controls
hold  in  1  freeze stage (downstream stall)
flush  in  1  kill incoming instruction (taken branch)
exmem_reg_write  in  1;  exmem_rd  in  REGW;  exmem_result  in  XLEN
memwb_reg_write  in  1;  memwb_rd  in  REGW;  memwb_result  in  XLEN
load_use_stall  out  1  to hazard/IF-ID: hold PC and IF/ID
A, B  out  XLEN  ALU operands
ALUOp  out  4  ALU operation
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  REGW;  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each

Behaviour:
- All state updates on posedge clk. Reset (synchronous, active-high) clears every register: ALUOp=0000, ex_rd=0, all controls and ex_valid=0, stored data/imm/indices=0. A, B and ex_store_data are therefore 0 unless forwarding matches. Reset mid-stream discards the held instruction.
- Update priority per edge: reset > flush (load bubble) > hold (keep all contents) > load_use_stall (load bubble) > load from id_*.
- Bubble: ex_valid, reg_write, mem_read, mem_write, mem_to_reg and ex_rd all 0; ALUOp=0000. Operand registers don't-care.
- Latency: id_* inputs sampled at edge N appear on ALUOp, A, B at N+1, then pass through combinational forwarding.
- ALUOp decode (registered):
  - alu_op 00 -> 0010.
  - alu_op 01 -> 0110.
  - alu_op 10: funct3 000 with f7b5=0 -> 0010; f7b5=1 -> 0110; funct3 111 -> 0000; 110 -> 0001; other -> 0010.
  - alu_op 11: funct3 000 -> 0010 (f7b5 ignored), 111 -> 0000, 110 -> 0001, other -> 0010.
- Forwarding A (combinational, from registered rs1):
  - exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1 -> exmem_result.
  - else the same test on memwb -> memwb_result.
  - else stored rs1 data.
  - EX/MEM wins when both match.
- Forward-B: same rule on rs2 -> ex_store_data.
- B = alu_src ? stored imm : ex_store_data.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). Combinational. Deasserts the cycle after the bubble enters.
- rd/rs index 0 never forwards and never stalls.
- hold and load_use_stall together: hold wins. The stall stays asserted and the bubble enters on the first non-hold edge.

Test Plan:
- Reset: assert reset 2 cycles with id_valid=1 and id_reg_write=1 -> ALUOp=0000, ex_valid=0, ex_reg_write=0, A=0, B=0.
- Decode and latency:
  - id_rs1_data=30, id_rs2_data=10, alu_op=10, funct3=000, f7b5=1, one edge -> A=30, B=10, ALUOp=0110.
  - alu_op=11, funct3=111, imm=7, alu_src=1 -> ALUOp=0000, B=7.
- Forwarding priority:
  - Stored rs1=5, exmem_rd=5 with result 40, memwb_rd=5 with result 99, both reg_write -> A=40.
  - Drop exmem_reg_write -> A=99.
  - Make rs1=0 with matches on index 0 -> A = stored data.
- Load-use: ex holds load to x3 (mem_read=1); id_rs2=3, id_valid=1 -> load_use_stall=1. Next edge loads bubble: ex_valid=0, ALUOp=0000. The following cycle load_use_stall=0.
- hold vs flush:
  - hold=1 for 3 edges with changing id_* -> outputs unchanged.
  - flush=1 together with hold=1 -> bubble loaded on that edge.
